// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types and default dimensions
package rf_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [RF_WIDTH-1:0]  word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy-bit scoreboard: pending writes, RAW/WAW hazards, issue stall
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_READ = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            rd,
    input  logic [NUM_READ*ADDR_W-1:0]   rs,
    input  logic                         issue,
    input  logic [ADDR_W-1:0]            issue_rd,
    input  logic                         flush,
    output logic [NUM_READ-1:0]          hazard,
    output logic                         stall,
    output logic [CNT_W-1:0]             pending
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0] rs_a;
    logic issue_zero;
    logic waw;

    always_comb begin
        hazard = '0;
        rs_a   = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rs_a      = rs[i*ADDR_W +: ADDR_W];
            hazard[i] = busy_q[rs_a] && !(BYP && write && (rd == rs_a));
        end
    end

    // A write landing on issue_rd this cycle retires the old producer, so no WAW.
    assign issue_zero = ZR && (issue_rd == '0);
    assign waw        = busy_q[issue_rd] && !(write && (rd == issue_rd)) && !issue_zero;
    assign stall      = issue && !flush && ((|hazard) || waw);

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (write) busy_d[rd] = 1'b0;
            if (issue && !stall && !issue_zero) busy_d[issue_rd] = 1'b1;
        end
        if (ZR) busy_d[0] = 1'b0;
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised RV32I register file with bypass and integrated scoreboard
module register_file_sb
    import rf_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_READ = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            rd,
    input  logic [WIDTH-1:0]             reg_write,
    input  logic [NUM_READ*ADDR_W-1:0]   rs,
    output logic [NUM_READ*WIDTH-1:0]    reg_rd,
    input  logic                         issue,
    input  logic [ADDR_W-1:0]            issue_rd,
    input  logic                         flush,
    output logic [NUM_READ-1:0]          hazard,
    output logic                         stall,
    output logic [CNT_W-1:0]             pending
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] rd_a;
    logic [WIDTH-1:0]  rd_data;

    assign wr_en = write && !(ZR && (rd == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rd] <= reg_write;
        end
    end

    // Reads are forced to zero while reset is held so bypassed write data cannot leak out.
    always_comb begin
        reg_rd  = '0;
        rd_a    = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_a = rs[i*ADDR_W +: ADDR_W];
            if (rst)                                rd_data = '0;
            else if (ZR && (rd_a == '0))            rd_data = '0;
            else if (BYP && write && (rd == rd_a))  rd_data = reg_write;
            else                                    rd_data = regs_q[rd_a];
            reg_rd[i*WIDTH +: WIDTH] = rd_data;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .rd       (rd),
        .rs       (rs),
        .issue    (issue),
        .issue_rd (issue_rd),
        .flush    (flush),
        .hazard   (hazard),
        .stall    (stall),
        .pending  (pending)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - directed table-driven bench for register_file_sb
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [4:0]  rd;
    logic [31:0] reg_write;
    logic [9:0]  rs;
    logic [63:0] reg_rd;
    logic        issue;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [1:0]  hazard;
    logic        stall;
    logic [5:0]  pending;

    logic [63:0] nb_rd;
    logic [1:0]  nb_hz;
    logic        nb_stall;
    logic [5:0]  nb_pend;

    logic        write4;
    logic [3:0]  rd4;
    logic [31:0] wd4;
    logic [15:0] rs4;
    logic [127:0] rdo4;
    logic        issue4;
    logic [3:0]  ird4;
    logic        flush4;
    logic [3:0]  hz4;
    logic        stall4;
    logic [4:0]  pend4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk(clk), .rst(rst), .write(write), .rd(rd), .reg_write(reg_write),
        .rs(rs), .reg_rd(reg_rd), .issue(issue), .issue_rd(issue_rd),
        .flush(flush), .hazard(hazard), .stall(stall), .pending(pending)
    );

    register_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .write(write), .rd(rd), .reg_write(reg_write),
        .rs(rs), .reg_rd(nb_rd), .issue(issue), .issue_rd(issue_rd),
        .flush(flush), .hazard(nb_hz), .stall(nb_stall), .pending(nb_pend)
    );

    register_file_sb #(.NUM_READ(4), .DEPTH(16)) dut4 (
        .clk(clk), .rst(rst), .write(write4), .rd(rd4), .reg_write(wd4),
        .rs(rs4), .reg_rd(rdo4), .issue(issue4), .issue_rd(ird4),
        .flush(flush4), .hazard(hz4), .stall(stall4), .pending(pend4)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        iss;
        logic [4:0]  ird;
        logic        fl;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ehz;
        logic        est;
        logic [5:0]  epend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic iss, input logic [4:0] ird, input logic fl,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] ehz, input logic est, input logic [5:0] ep);
        vec_t v;
        v = '{wr, a, wd, r0, r1, iss, ird, fl, e0, e1, ehz, est, ep};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        write = 1'b0; rd = '0; reg_write = '0; rs = '0;
        issue = 1'b0; issue_rd = '0; flush = 1'b0;
        write4 = 1'b0; rd4 = '0; wd4 = '0; rs4 = '0;
        issue4 = 1'b0; ird4 = '0; flush4 = 1'b0;
    endtask

    task automatic start();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        write = 1'b1; rd = 5'd5; reg_write = 32'hDEAD; rs = {5'd5, 5'd5};
        @(negedge clk);
        chk("rst_held rd0", reg_rd[31:0], 32'h0);
        chk("rst_held pend", 32'(pending), 32'h0);
        chk("rst_held hz", 32'(hazard), 32'h0);
        #1;
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel rd1", reg_rd[63:32], 32'h0);
        chk("rst_rel stall", 32'(stall), 32'h0);
        chk("rst_rel pend", 32'(pending), 32'h0);

        //   wr    rd     wd            rs0    rs1    iss   ird    fl    e0            e1            hz     st    pend
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd3, 32'h1234,     5'd3,  5'd3,  1'b0, 5'd0,  1'b0, 32'h1234,     32'h1234,     2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 32'h1234,     32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd3,  1'b0, 5'd0,  1'b0, 32'h0,        32'h1234,     2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd7,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd7,  5'd3,  1'b1, 5'd8,  1'b0, 32'h0,        32'h1234,     2'b01, 1'b1, 6'd1);
        add(1'b1, 5'd7, 32'h55,       5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'h55,       32'h55,       2'b00, 1'b0, 6'd1);
        add(1'b0, 5'd0, 32'h0,        5'd7,  5'd8,  1'b0, 5'd0,  1'b0, 32'h55,       32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd9,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd9,  1'b0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd1);
        add(1'b1, 5'd9, 32'hA,        5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'hA,        32'h0,        2'b00, 1'b0, 6'd1);
        add(1'b0, 5'd0, 32'h0,        5'd9,  5'd9,  1'b0, 5'd0,  1'b0, 32'hA,        32'hA,        2'b11, 1'b0, 6'd1);
        add(1'b1, 5'd9, 32'hB,        5'd9,  5'd0,  1'b0, 5'd0,  1'b0, 32'hB,        32'h0,        2'b00, 1'b0, 6'd1);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd1,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd2,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd1);
        add(1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd4,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd2);
        add(1'b0, 5'd0, 32'h0,        5'd1,  5'd6,  1'b1, 5'd6,  1'b1, 32'h0,        32'h0,        2'b01, 1'b0, 6'd3);
        add(1'b0, 5'd0, 32'h0,        5'd6,  5'd1,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd1, 32'h77,       5'd1,  5'd9,  1'b0, 5'd0,  1'b0, 32'h77,       32'hB,        2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0,        5'd1,  5'd3,  1'b0, 5'd0,  1'b0, 32'h77,       32'h1234,     2'b00, 1'b0, 6'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            start();
            write = tbl[i].wr; rd = tbl[i].rd; reg_write = tbl[i].wd;
            rs = {tbl[i].rs1, tbl[i].rs0};
            issue = tbl[i].iss; issue_rd = tbl[i].ird; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d rd0", i), reg_rd[31:0], tbl[i].e0);
            chk($sformatf("v%0d rd1", i), reg_rd[63:32], tbl[i].e1);
            chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(tbl[i].ehz));
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].est));
            chk($sformatf("v%0d pending", i), 32'(pending), 32'(tbl[i].epend));
        end

        // asynchronous reset in the middle of a cycle
        start();
        write = 1'b1; rd = 5'd5; reg_write = 32'hDEAD; issue = 1'b1; issue_rd = 5'd6;
        start();
        rs = {5'd6, 5'd5};
        #1;
        chk("pre_rst rd0", reg_rd[31:0], 32'hDEAD);
        chk("pre_rst pend", 32'(pending), 32'h1);
        chk("pre_rst hz", 32'(hazard), 32'h2);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst rd0", reg_rd[31:0], 32'h0);
        chk("mid_rst pend", 32'(pending), 32'h0);
        chk("mid_rst hz", 32'(hazard), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst rd0", reg_rd[31:0], 32'h0);
        chk("post_rst pend", 32'(pending), 32'h0);

        // no-bypass instance: reads see the old value until the write commits
        start();
        write = 1'b1; rd = 5'd3; reg_write = 32'h1234; rs = {5'd3, 5'd3};
        @(negedge clk);
        chk("nb same_cycle rd1", nb_rd[63:32], 32'h0);
        chk("byp same_cycle rd1", reg_rd[63:32], 32'h1234);
        start();
        rs = {5'd3, 5'd3};
        @(negedge clk);
        chk("nb next_cycle rd1", nb_rd[63:32], 32'h1234);
        start();
        issue = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("nb issue pend", 32'(nb_pend), 32'h0);
        start();
        write = 1'b1; rd = 5'd7; reg_write = 32'h55; rs = {5'd0, 5'd7};
        @(negedge clk);
        chk("nb wb hz", 32'(nb_hz), 32'h1);
        chk("nb wb rd0", nb_rd[31:0], 32'h0);
        chk("nb wb pend", 32'(nb_pend), 32'h1);
        start();
        rs = {5'd0, 5'd7};
        @(negedge clk);
        chk("nb after hz", 32'(nb_hz), 32'h0);
        chk("nb after rd0", nb_rd[31:0], 32'h55);
        chk("nb after pend", 32'(nb_pend), 32'h0);

        // four read ports, sixteen registers
        start();
        write4 = 1'b1; rd4 = 4'd3; wd4 = 32'h1234; rs4 = {4'd5, 4'd0, 4'd3, 4'd3};
        @(negedge clk);
        chk("p4 byp port0", rdo4[31:0], 32'h1234);
        chk("p4 byp port1", rdo4[63:32], 32'h1234);
        chk("p4 byp port2", rdo4[95:64], 32'h0);
        chk("p4 byp port3", rdo4[127:96], 32'h0);
        start();
        write4 = 1'b1; rd4 = 4'd15; wd4 = 32'hF00D; issue4 = 1'b1; ird4 = 4'd7;
        rs4 = {4'd3, 4'd3, 4'd3, 4'd3};
        @(negedge clk);
        chk("p4 reg port3", rdo4[127:96], 32'h1234);
        chk("p4 issue stall", 32'(stall4), 32'h0);
        start();
        issue4 = 1'b1; ird4 = 4'd8; rs4 = {4'd7, 4'd15, 4'd7, 4'd7};
        @(negedge clk);
        chk("p4 raw hz", 32'(hz4), 32'hB);
        chk("p4 raw stall", 32'(stall4), 32'h1);
        chk("p4 raw pend", 32'(pend4), 32'h1);
        chk("p4 top reg", rdo4[95:64], 32'hF00D);
        start();
        write4 = 1'b1; rd4 = 4'd7; wd4 = 32'h55; rs4 = {4'd7, 4'd7, 4'd7, 4'd7};
        @(negedge clk);
        chk("p4 wb hz", 32'(hz4), 32'h0);
        chk("p4 wb port3", rdo4[127:96], 32'h55);
        chk("p4 wb pend", 32'(pend4), 32'h1);
        start();
        rs4 = {4'd0, 4'd0, 4'd0, 4'd7};
        @(negedge clk);
        chk("p4 after pend", 32'(pend4), 32'h0);
        chk("p4 after port0", rdo4[31:0], 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
